// File: rtl/instruction_fetch.sv
// Instruction fetch: holds each program word on iin for CPI cycles, aligned to a
// free-running phase counter so word changes land on the core's step-0 boundary.
module instruction_fetch #(
   parameter int          DEPTH     = 16,
   parameter int          AW        = 4,
   parameter int          CPI       = 4,
   parameter logic [15:0] HALT_WORD = 16'hFFFF,
   parameter logic [15:0] NOP_WORD  = 16'h0000
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [15:0]   load_data,
   input  logic          start,
   output logic [15:0]   iin,
   output logic [AW-1:0] pc,
   output logic          running,
   output logic          halted,
   output logic          load_err
);
   localparam int            PW      = (CPI > 1) ? $clog2(CPI) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(CPI - 1);
   localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

   state_t        state, state_n;
   logic [PW-1:0] ph;
   logic          start_pending, pend_n;
   logic [15:0]   iin_n;
   logic [AW-1:0] pc_n, pc_inc;
   logic          err_n, wrap;
   logic [15:0]   word0, word_nx;
   logic [15:0]   mem [DEPTH];

   assign wrap    = (ph == PH_LAST);
   assign pc_inc  = pc + 1'b1;
   // Combinational reads see pre-write contents on a colliding load.
   assign word0   = mem[0];
   assign word_nx = mem[pc_inc];

   // Program store is deliberately not reset so it survives resetn.
   always_ff @(posedge clock) begin
      if (load_en && state != S_RUN) mem[load_addr] <= load_data;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ph            <= '0;
         state         <= S_IDLE;
         start_pending <= 1'b0;
         iin           <= NOP_WORD;
         pc            <= '0;
         running       <= 1'b0;
         halted        <= 1'b0;
         load_err      <= 1'b0;
      end else begin
         ph            <= wrap ? '0 : ph + 1'b1;
         state         <= state_n;
         start_pending <= pend_n;
         iin           <= iin_n;
         pc            <= pc_n;
         running       <= (state_n == S_RUN);
         halted        <= (state_n == S_HALTED);
         load_err      <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      pend_n  = start_pending;
      iin_n   = iin;
      pc_n    = pc;
      err_n   = load_en && (state == S_RUN);
      unique case (state)
         S_RUN: begin
            if (wrap) begin
               // No wrap-around past the last word; HALT_WORD is never issued.
               if (pc == PC_LAST || word_nx == HALT_WORD) begin
                  state_n = S_HALTED;
                  iin_n   = NOP_WORD;
               end else begin
                  pc_n  = pc_inc;
                  iin_n = word_nx;
               end
            end
         end
         default: begin
            if (start) pend_n = 1'b1;
            if (wrap && (start_pending || start)) begin
               pend_n = 1'b0;
               if (word0 == HALT_WORD) begin
                  state_n = S_HALTED;
                  iin_n   = NOP_WORD;
               end else begin
                  state_n = S_RUN;
                  pc_n    = '0;
                  iin_n   = word0;
               end
            end
         end
      endcase
   end
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected (word, pc) pairs are queued when
// a run is launched and checked cycle by cycle as the fetch unit presents them.
module tb_instruction_fetch;
   localparam int CPI = 4;

   logic        clock = 1'b0;
   logic        resetn, load_en, start;
   logic [3:0]  load_addr, pc;
   logic [15:0] load_data, iin;
   logic        running, halted, load_err;
   logic [1:0]  tb_ph;

   typedef struct packed {
      logic [15:0] w;
      logic [3:0]  pc;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   instruction_fetch dut (
      .clock(clock), .resetn(resetn), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .start(start), .iin(iin), .pc(pc),
      .running(running), .halted(halted), .load_err(load_err)
   );

   always #5 clock = ~clock;

   // Reference phase: counts edges since reset release, mod CPI.
   always @(posedge clock or negedge resetn) begin
      if (!resetn) tb_ph <= 2'd0;
      else         tb_ph <= (int'(tb_ph) == CPI - 1) ? 2'd0 : tb_ph + 2'd1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %0h expected %0h", tag, got, exp);
   endtask

   task automatic load(input logic [3:0] a, input logic [15:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      @(negedge clock);
      load_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_ph(input logic [1:0] v);
      int n = 0;
      while (tb_ph != v && n < 2 * CPI) begin @(negedge clock); n++; end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_iin"}, iin, 16'h0000);
      chk({tag, "_pc"}, pc, 0);
      chk({tag, "_run"}, running, 0);
      chk({tag, "_halt"}, halted, 0);
      chk({tag, "_err"}, load_err, 0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
   endtask

   // Consumes the queue: each word must be held exactly CPI cycles, then HALTED.
   task automatic drain(input string tag, input logic [3:0] fpc, input int inj);
      int   n = 0;
      int   k = 0;
      exp_t e;
      while (!running && n < 3 * CPI) begin @(negedge clock); n++; end
      chk({tag, "_started"}, running, 1);
      chk({tag, "_ph0"}, tb_ph, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int c = 0; c < CPI; c++) begin
            chk({tag, "_iin"}, iin, e.w);
            chk({tag, "_pc"}, pc, e.pc);
            if (inj >= 0 && k == inj) begin
               load_en = 1'b1; load_addr = 4'd3; load_data = 16'hAAAA;
            end
            if (inj >= 0 && k == inj + 1) begin
               load_en = 1'b0;
               chk({tag, "_err1"}, load_err, 1);
            end
            if (inj >= 0 && k == inj + 2) chk({tag, "_err0"}, load_err, 0);
            k++;
            @(negedge clock);
         end
      end
      chk({tag, "_halted"}, halted, 1);
      chk({tag, "_stopped"}, running, 0);
      chk({tag, "_nop"}, iin, 16'h0000);
      chk({tag, "_fpc"}, pc, fpc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      resetn = 1'b0; load_en = 1'b0; start = 1'b0; load_addr = '0; load_data = '0;
      repeat (2) @(negedge clock);
      check_reset("rst");
      resetn = 1'b1;

      // Short program ending in HALT_WORD, start issued at ph=1
      load(4'd0, 16'h1240); load(4'd1, 16'h2480); load(4'd2, 16'hFFFF);
      chk("load_ok", load_err, 0);
      wait_ph(2'd1);
      exp_q.push_back('{16'h1240, 4'd0});
      exp_q.push_back('{16'h2480, 4'd1});
      pulse_start();
      drain("t1", 4'd1, -1);

      // Restart from HALTED always begins at address 0
      exp_q.push_back('{16'h1240, 4'd0});
      exp_q.push_back('{16'h2480, 4'd1});
      pulse_start();
      drain("t5a", 4'd1, -1);

      // HALT_WORD at address 0: straight to HALTED, iin stays NOP
      do_reset();
      load(4'd0, 16'hFFFF);
      pulse_start();
      for (int c = 0; c < CPI + 1; c++) begin
         chk("t5b_iin", iin, 16'h0000);
         chk("t5b_run", running, 0);
         @(negedge clock);
      end
      chk("t5b_halt", halted, 1);

      // Full 16-word program, rejected load while running
      for (int i = 0; i < 16; i++) load(4'(i), 16'h0041 + 16'(i));
      for (int i = 0; i < 16; i++) exp_q.push_back('{16'h0041 + 16'(i), 4'(i)});
      pulse_start();
      drain("t2", 4'd15, 5);

      // Asynchronous reset mid-instruction, then re-run retained program
      pulse_start();
      n = 0;
      while (!running && n < 3 * CPI) begin @(negedge clock); n++; end
      repeat (6) @(negedge clock);
      #2 resetn = 1'b0;
      #1 check_reset("t4");
      @(negedge clock);
      resetn = 1'b1;
      for (int i = 0; i < 16; i++) exp_q.push_back('{16'h0041 + 16'(i), 4'(i)});
      pulse_start();
      drain("t4r", 4'd15, -1);

      // Load colliding with the launching wrap edge reads old mem[0]
      do_reset();
      load(4'd0, 16'h1111); load(4'd1, 16'hFFFF);
      wait_ph(2'd1);
      pulse_start();
      wait_ph(2'd3);
      load(4'd0, 16'h5555);
      exp_q.push_back('{16'h1111, 4'd0});
      drain("t6", 4'd0, -1);
      exp_q.push_back('{16'h5555, 4'd0});
      pulse_start();
      drain("t6b", 4'd0, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream stage of the processor core: stores a small program and drives the core's 16-bit instruction input `iin`.
- The core decodes `iin[15:7]` over a fixed number of step cycles per instruction. This block therefore holds each instruction word stable for exactly `CPI` cycles, then advances.
- It keeps a free-running phase counter reset by the same `resetn` as the core's step counter, so instruction changes land on the core's step-0 boundary.
- A load port writes the program while the block is idle.

Parameters:
- DEPTH, 16: number of 16-bit program words; power of two.
- AW, 4: address width, log2(DEPTH).
- CPI, 4: cycles each instruction is held; must equal the core's step count.
- HALT_WORD, 16'hFFFF: instruction value that ends execution; never presented to the core.
- NOP_WORD, 16'h0000: word driven on `iin` when not running.

Ports:
- clock, input, 1: rising-edge clock.
- resetn, input, 1: asynchronous active-low reset.
- load_en, input, 1: write `load_data` to `mem[load_addr]` this cycle.
- load_addr, input, AW: program write address.
- load_data, input, 16: program write data.
- start, input, 1: single-cycle request to run from address 0.
- iin, output, 16: registered instruction word to the core.
- pc, output, AW: address of the word currently on `iin`.
- running, output, 1: high while in RUN.
- halted, output, 1: high while in HALTED.
- load_err, output, 1: one-cycle pulse when `load_en` is rejected.

Behaviour:
- Reset values: `iin`=NOP_WORD, `pc`=0, `running`=0, `halted`=0, `load_err`=0. Phase counter `ph`=0, `start_pending`=0, state=IDLE.
- Program memory is not reset; its contents survive `resetn`.
- `ph` counts 0..CPI-1 and wraps, free-running in every state. The "wrap edge" is the rising edge at which `ph`==CPI-1.
- States: IDLE, RUN, HALTED. All outputs are registered.
- IDLE:
  - `load_en` writes memory on the edge.
  - `start` sets `start_pending`.
  - At the wrap edge with `start_pending` (or `start` asserted that same cycle):
    - if `mem[0]`==HALT_WORD: go to HALTED, `iin` stays NOP_WORD.
    - otherwise: go to RUN, `pc`<=0, `iin`<=`mem[0]`, clear pending.
  - Result: a new word appears on the cycle where `ph`==0.
- RUN, at each wrap edge, with `n` = `pc`+1:
  - if `pc`==DEPTH-1 (no wrap-around): go to HALTED.
  - else if `mem[n]`==HALT_WORD: go to HALTED.
  - else: `pc`<=`n`, `iin`<=`mem[n]`.
  - On entry to HALTED: `iin`<=NOP_WORD, `pc` holds its last value.
  - Between wrap edges, `iin` and `pc` are stable.
- HALTED:
  - Loads are allowed.
  - `start` sets `start_pending` and behaves as in IDLE; the restart is always from 0. `halted` clears when RUN is entered.
- `load_en` in RUN:
  - No write occurs.
  - `load_err`=1 on the next cycle, for one cycle per rejected request.
- `start` in RUN: ignored, no error.
- Simultaneous `load_en` and the wrap edge in IDLE with start pending:
  - the write completes;
  - the fetch reads the pre-write contents when addresses collide (read-before-write).
- `running` = (state==RUN); `halted` = (state==HALTED).
- Mid-operation reset: all outputs and state return to reset values immediately, asynchronously, on `resetn` low. Memory is retained.
- Latency: at most CPI cycles from the `start` pulse to the first instruction.

Test Plan (CPI=4, DEPTH=16):
1. Load mem[0..2]=16'h1240,16'h2480,16'hFFFF. Pulse `start` at `ph`=1.
   - `iin`=1240 appears when `ph`=0 and holds 4 cycles.
   - Then `iin`=2480 for 4 cycles.
   - Then `iin`=0000, `halted`=1, `pc`=1; 16'hFFFF never appears on `iin`.
2. Fill all 16 words with 16'h0041+i and start.
   - `pc` steps 0..15, each held 4 cycles.
   - After the 16th word, HALTED with `pc`=15; no wrap to 0.
3. Pulse `load_en` (addr 3, data 16'hAAAA) while running.
   - `load_err`=1 for one cycle.
   - `mem[3]` is unchanged when later fetched.
4. Assert `resetn`=0 asynchronously mid-instruction in RUN.
   - Outputs immediately read 0000/0/0/0.
   - After release, `start` re-runs the retained program from `mem[0]`.
5. From HALTED, pulse `start`: execution restarts at `pc`=0 on the next wrap edge and `halted` clears. With mem[0]=16'hFFFF, `start` goes straight to HALTED and `iin` stays 0000.
6. In IDLE, assert `load_en` (addr 0, data 16'h5555) on the same cycle as the wrap edge with start pending: `iin` shows the old `mem[0]`; 16'h5555 is fetched on the next run.
